// File: rtl/cluster_clk_ctrl_pkg.sv
// Shared types for the cluster clock-gate controller.
// Holds the FSM state encoding and wake-window limits.
package cluster_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    CC_RUN       = 2'd0,
    CC_IDLE_WAIT = 2'd1,
    CC_GATED     = 2'd2,
    CC_WAKE      = 2'd3
  } cc_state_e;

  localparam int unsigned WAKE_CYCLES_MAX = 15;
  localparam int unsigned WAKE_CNT_W      = 4;

endpackage

// File: rtl/cluster_clock_gate_ctrl.sv
// Cluster clock-gate enable controller with gate_req/gate_ack handshake.
// Ports: clk_i, rst_ni, test_mode_i, gate_req_i, busy_i, wake_i,
//   idle_thresh_i -> clk_en_o, gate_ack_o, state_o (all registered).
module cluster_clock_gate_ctrl
  import cluster_clk_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CNT_W  = 8,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_mode_i,
  input  logic                  gate_req_i,
  input  logic                  busy_i,
  input  logic                  wake_i,
  input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
  output logic                  clk_en_o,
  output logic                  gate_ack_o,
  output logic [1:0]            state_o
);

  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST =
    (WAKE_CYCLES == 0) ? '0 : WAKE_CNT_W'(WAKE_CYCLES - 1);

  cc_state_e               state_d, state_q;
  logic [IDLE_CNT_W-1:0]   idle_cnt_d, idle_cnt_q;
  logic [IDLE_CNT_W-1:0]   thresh_d, thresh_q;
  logic [WAKE_CNT_W-1:0]   wake_cnt_d, wake_cnt_q;
  logic                    clk_en_d, clk_en_q;
  logic                    gate_ack_d, gate_ack_q;
  logic [1:0]              state_o_d, state_o_q;
  logic                    abort;

  assign abort = busy_i | wake_i | ~gate_req_i;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    thresh_d   = thresh_q;
    wake_cnt_d = wake_cnt_q;
    if (test_mode_i) begin
      state_d    = CC_RUN;
      idle_cnt_d = '0;
      wake_cnt_d = '0;
    end else begin
      case (state_q)
        CC_RUN: begin
          if (gate_req_i && !busy_i) begin
            state_d    = CC_IDLE_WAIT;
            idle_cnt_d = '0;
            thresh_d   = idle_thresh_i;
          end
        end
        CC_IDLE_WAIT: begin
          // abort beats a threshold match in the same cycle
          if (abort) begin
            state_d = CC_RUN;
          end else if (idle_cnt_q == thresh_q) begin
            state_d = CC_GATED;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        CC_GATED: begin
          if (wake_i || !gate_req_i) begin
            wake_cnt_d = '0;
            state_d    = (WAKE_CYCLES == 0) ? CC_RUN : CC_WAKE;
          end
        end
        CC_WAKE: begin
          if (wake_cnt_q == WAKE_LAST) begin
            state_d = CC_RUN;
          end else begin
            wake_cnt_d = wake_cnt_q + 1'b1;
          end
        end
        default: state_d = CC_RUN;
      endcase
    end
  end

  // Outputs follow the current state one cycle later; test mode
  // bypasses that lag so the clock returns on the next edge.
  always_comb begin
    clk_en_d   = test_mode_i | (state_q != CC_GATED);
    gate_ack_d = ~test_mode_i & (state_q == CC_GATED);
    state_o_d  = test_mode_i ? CC_RUN : state_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CC_RUN;
      idle_cnt_q <= '0;
      thresh_q   <= '0;
      wake_cnt_q <= '0;
      clk_en_q   <= 1'b1;
      gate_ack_q <= 1'b0;
      state_o_q  <= CC_RUN;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      thresh_q   <= thresh_d;
      wake_cnt_q <= wake_cnt_d;
      clk_en_q   <= clk_en_d;
      gate_ack_q <= gate_ack_d;
      state_o_q  <= state_o_d;
    end
  end

  assign clk_en_o   = clk_en_q;
  assign gate_ack_o = gate_ack_q;
  assign state_o    = state_o_q;

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Self-checking bench for cluster_clock_gate_ctrl.
// Directed vector table plus hand-written busy-abort and reset sequences.
module tb_cluster_clock_gate_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       test_mode_i;
  logic       gate_req_i;
  logic       busy_i;
  logic       wake_i;
  logic [7:0] idle_thresh_i;
  logic       clk_en_o;
  logic       gate_ack_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cluster_clock_gate_ctrl #(
    .IDLE_CNT_W (8),
    .WAKE_CYCLES(2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .test_mode_i  (test_mode_i),
    .gate_req_i   (gate_req_i),
    .busy_i       (busy_i),
    .wake_i       (wake_i),
    .idle_thresh_i(idle_thresh_i),
    .clk_en_o     (clk_en_o),
    .gate_ack_o   (gate_ack_o),
    .state_o      (state_o)
  );

  typedef struct {
    logic       tm;
    logic       req;
    logic       busy;
    logic       wake;
    logic [7:0] thr;
    logic       en;
    logic       ack;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic tm, logic req, logic busy,
                              logic wake, logic [7:0] thr,
                              logic en, logic ack, logic [1:0] st);
    vec_t v;
    v.tm = tm; v.req = req; v.busy = busy; v.wake = wake;
    v.thr = thr; v.en = en; v.ack = ack; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // drive at negedge, let one posedge happen, sample at next negedge
  task automatic cyc(input logic tm, input logic req, input logic busy,
                     input logic wake, input logic [7:0] thr);
    test_mode_i   = tm;
    gate_req_i    = req;
    busy_i        = busy;
    wake_i        = wake;
    idle_thresh_i = thr;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // thr=3 gating, wake with second wake ignored
    vecs[0]  = mk(0, 1, 0, 0, 3, 1, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 3, 1, 0, 1);
    vecs[2]  = mk(0, 1, 0, 0, 3, 1, 0, 1);
    vecs[3]  = mk(0, 1, 0, 0, 3, 1, 0, 1);
    vecs[4]  = mk(0, 1, 0, 0, 3, 1, 0, 1);
    vecs[5]  = mk(0, 1, 0, 0, 3, 0, 1, 2);
    vecs[6]  = mk(0, 1, 0, 1, 3, 0, 1, 2);
    vecs[7]  = mk(0, 1, 0, 0, 3, 1, 0, 3);
    vecs[8]  = mk(0, 1, 0, 1, 3, 1, 0, 3);
    vecs[9]  = mk(0, 1, 1, 0, 3, 1, 0, 0);
    // thr=0 gating, request dropped in GATED
    vecs[10] = mk(0, 1, 0, 0, 0, 1, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 0, 1, 0, 1);
    vecs[12] = mk(0, 1, 0, 0, 0, 0, 1, 2);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 2);
    vecs[14] = mk(0, 0, 0, 0, 0, 1, 0, 3);
    vecs[15] = mk(0, 0, 0, 0, 0, 1, 0, 3);
    vecs[16] = mk(0, 0, 0, 0, 0, 1, 0, 0);
    // threshold match together with busy
    vecs[17] = mk(0, 1, 0, 0, 1, 1, 0, 0);
    vecs[18] = mk(0, 1, 0, 0, 1, 1, 0, 1);
    vecs[19] = mk(0, 1, 1, 0, 1, 1, 0, 1);
    vecs[20] = mk(0, 0, 0, 0, 1, 1, 0, 0);
    // test mode in GATED, then held with request high
    vecs[21] = mk(0, 1, 0, 0, 0, 1, 0, 0);
    vecs[22] = mk(0, 1, 0, 0, 0, 1, 0, 1);
    vecs[23] = mk(0, 1, 0, 0, 0, 0, 1, 2);
    vecs[24] = mk(1, 1, 0, 0, 0, 1, 0, 0);
    vecs[25] = mk(1, 1, 0, 0, 0, 1, 0, 0);
    vecs[26] = mk(1, 1, 0, 0, 0, 1, 0, 0);
    vecs[27] = mk(0, 0, 0, 0, 0, 1, 0, 0);

    rst_ni = 1'b0;
    test_mode_i = 0; gate_req_i = 0; busy_i = 0; wake_i = 0;
    idle_thresh_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_clk_en", clk_en_o, 1);
    chk("rst_gate_ack", gate_ack_o, 0);
    chk("rst_state", state_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_state", state_o, 0);

    for (int i = 0; i < 28; i++) begin
      cyc(vecs[i].tm, vecs[i].req, vecs[i].busy, vecs[i].wake,
          vecs[i].thr);
      chk($sformatf("v%0d_clk_en", i), clk_en_o, vecs[i].en);
      chk($sformatf("v%0d_gate_ack", i), gate_ack_o, vecs[i].ack);
      chk($sformatf("v%0d_state", i), state_o, vecs[i].st);
    end

    // thr=5, busy at the 4th IDLE_WAIT cycle aborts; restart from edge 5
    // must gate at edge 5+5+2=12 and not before
    for (int k = 0; k <= 12; k++) begin
      cyc(0, 1, (k == 4), 0, 5);
      chk($sformatf("abort_k%0d_ack", k), gate_ack_o, (k == 12));
      chk($sformatf("abort_k%0d_clk_en", k), clk_en_o, (k != 12));
      if (k == 5) chk("abort_state_run", state_o, 0);
    end

    // async reset while GATED acts without a clock edge
    #1 rst_ni = 1'b0;
    #1;
    chk("async_rst_clk_en", clk_en_o, 1);
    chk("async_rst_gate_ack", gate_ack_o, 0);
    chk("async_rst_state", state_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk("rel_state", state_o, 0);
    chk("rel_clk_en", clk_en_o, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
